// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//   Per-pin input conditioning for the AHB GPIO port. Raw pad levels are
//   synchronised into HCLK by a 2-flop chain. Each pin is then either passed
//   straight through or debounced against a shared prescaler tick. The result
//   drives GPIO_DIN, along with single-cycle edge pulses and sticky edge flags.
//
// Ports
//   HCLK       in   system clock
//   HRESETn    in   asynchronous active-low reset
//   PAD_IN     in   [SZ]  raw asynchronous pad inputs
//   DB_EN      in   [SZ]  per-pin debounce enable (0 = bypass)
//   PRESCALE   in   [PSW] debounce tick period minus 1, in HCLK cycles
//   EDGE_CLR   in   [SZ]  per-pin level clear for the sticky flags
//   DIN_CLEAN  out  [SZ]  conditioned pin value
//   RISE       out  [SZ]  one-cycle pulse on a 0->1 change of DIN_CLEAN
//   FALL       out  [SZ]  one-cycle pulse on a 1->0 change of DIN_CLEAN
//   RISE_FLAG  out  [SZ]  sticky rising-edge flag
//   FALL_FLAG  out  [SZ]  sticky falling-edge flag

module gpio_in_conditioner #(
    parameter int unsigned SZ     = 8,
    parameter int unsigned DB_CNT = 4,
    parameter int unsigned PSW    = 16
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    input  logic [SZ-1:0]  PAD_IN,
    input  logic [SZ-1:0]  DB_EN,
    input  logic [PSW-1:0] PRESCALE,
    input  logic [SZ-1:0]  EDGE_CLR,
    output logic [SZ-1:0]  DIN_CLEAN,
    output logic [SZ-1:0]  RISE,
    output logic [SZ-1:0]  FALL,
    output logic [SZ-1:0]  RISE_FLAG,
    output logic [SZ-1:0]  FALL_FLAG
);

    localparam int unsigned CW = $clog2(DB_CNT + 1);
    localparam logic [CW-1:0] DbLast = CW'(DB_CNT - 1);

    logic [SZ-1:0]          s1_q, s2_q;
    logic [PSW-1:0]         presc_q, presc_d;
    logic                   tick;
    logic [SZ-1:0][CW-1:0]  dbc_q, dbc_d;
    logic [SZ-1:0]          din_q, din_d;
    logic [SZ-1:0]          clean_d_q;
    logic [SZ-1:0]          rise_flag_q, rise_flag_d;
    logic [SZ-1:0]          fall_flag_q, fall_flag_d;
    logic [SZ-1:0]          rise, fall;

    // '>=' rather than '==' so that lowering PRESCALE below the current count
    // wraps on the next edge instead of running all the way to 2^PSW.
    always_comb begin
        tick    = (presc_q >= PRESCALE);
        presc_d = tick ? '0 : presc_q + PSW'(1);
    end

    always_comb begin
        din_d = din_q;
        dbc_d = dbc_q;
        for (int i = 0; i < int'(SZ); i++) begin
            if (!DB_EN[i]) begin
                din_d[i] = s2_q[i];
                dbc_d[i] = '0;
            end else if (s2_q[i] == din_q[i]) begin
                // Any return to the accepted level restarts the acceptance window.
                dbc_d[i] = '0;
            end else if (tick) begin
                if (dbc_q[i] == DbLast) begin
                    din_d[i] = s2_q[i];
                    dbc_d[i] = '0;
                end else begin
                    dbc_d[i] = dbc_q[i] + CW'(1);
                end
            end
        end
    end

    // Edges decoded purely from registers, so the pulses are glitch-free.
    always_comb begin
        rise        = din_q & ~clean_d_q;
        fall        = ~din_q & clean_d_q;
        // Set wins over a simultaneous clear.
        rise_flag_d = rise | (rise_flag_q & ~EDGE_CLR);
        fall_flag_d = fall | (fall_flag_q & ~EDGE_CLR);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1_q        <= '0;
            s2_q        <= '0;
            presc_q     <= '0;
            dbc_q       <= '0;
            din_q       <= '0;
            clean_d_q   <= '0;
            rise_flag_q <= '0;
            fall_flag_q <= '0;
        end else begin
            s1_q        <= PAD_IN;
            s2_q        <= s1_q;
            presc_q     <= presc_d;
            dbc_q       <= dbc_d;
            din_q       <= din_d;
            clean_d_q   <= din_q;
            rise_flag_q <= rise_flag_d;
            fall_flag_q <= fall_flag_d;
        end
    end

    assign DIN_CLEAN = din_q;
    assign RISE      = rise;
    assign FALL      = fall;
    assign RISE_FLAG = rise_flag_q;
    assign FALL_FLAG = fall_flag_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: a vector table for the bypass
// path, directed multi-cycle sequences for debounce / flags / prescaler, and
// a randomized run compared every cycle against a behavioural model.

module tb_gpio_in_conditioner;

    localparam int SZ     = 8;
    localparam int DB_CNT = 4;
    localparam int PSW    = 16;

    logic           HCLK = 1'b0;
    logic           HRESETn = 1'b1;
    logic [SZ-1:0]  PAD_IN = '0;
    logic [SZ-1:0]  DB_EN = '0;
    logic [PSW-1:0] PRESCALE = '0;
    logic [SZ-1:0]  EDGE_CLR = '0;
    logic [SZ-1:0]  DIN_CLEAN, RISE, FALL, RISE_FLAG, FALL_FLAG;

    gpio_in_conditioner #(.SZ(SZ), .DB_CNT(DB_CNT), .PSW(PSW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .PAD_IN    (PAD_IN),
        .DB_EN     (DB_EN),
        .PRESCALE  (PRESCALE),
        .EDGE_CLR  (EDGE_CLR),
        .DIN_CLEAN (DIN_CLEAN),
        .RISE      (RISE),
        .FALL      (FALL),
        .RISE_FLAG (RISE_FLAG),
        .FALL_FLAG (FALL_FLAG)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pad samples age through two sync slots, a pin's new
    // level is accepted after DB_CNT prescaler ticks spent continuously
    // different from the accepted level.
    logic [SZ-1:0] m_s1, m_s2, m_clean, m_prev, m_rf, m_ff;
    int            m_cnt;
    int            m_ticks [SZ];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_prev = '0; m_rf = '0; m_ff = '0;
        m_cnt = 0;
        for (int i = 0; i < SZ; i++) m_ticks[i] = 0;
    endtask

    task automatic model_step(input logic [SZ-1:0] pad, input logic [SZ-1:0] en,
                              input logic [SZ-1:0] clr, input int pre);
        logic          t;
        logic [SZ-1:0] r, f, nclean;
        t      = (m_cnt >= pre);
        r      = m_clean & ~m_prev;
        f      = m_prev & ~m_clean;
        nclean = m_clean;
        for (int i = 0; i < SZ; i++) begin
            if (!en[i]) begin
                m_ticks[i] = 0;
                nclean[i]  = m_s2[i];
            end else if (m_s2[i] == m_clean[i]) begin
                m_ticks[i] = 0;
            end else if (t) begin
                m_ticks[i] = m_ticks[i] + 1;
                if (m_ticks[i] == DB_CNT) begin
                    nclean[i]  = m_s2[i];
                    m_ticks[i] = 0;
                end
            end
        end
        m_rf    = r | (m_rf & ~clr);
        m_ff    = f | (m_ff & ~clr);
        m_prev  = m_clean;
        m_clean = nclean;
        m_s2    = m_s1;
        m_s1    = pad;
        m_cnt   = t ? 0 : m_cnt + 1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " DIN_CLEAN"}, 16'(DIN_CLEAN), 16'(m_clean));
        check({tag, " RISE"},      16'(RISE),      16'(m_clean & ~m_prev));
        check({tag, " FALL"},      16'(FALL),      16'(m_prev & ~m_clean));
        check({tag, " RISE_FLAG"}, 16'(RISE_FLAG), 16'(m_rf));
        check({tag, " FALL_FLAG"}, 16'(FALL_FLAG), 16'(m_ff));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " DIN_CLEAN"}, 16'(DIN_CLEAN), 16'h0);
        check({tag, " RISE"},      16'(RISE),      16'h0);
        check({tag, " FALL"},      16'(FALL),      16'h0);
        check({tag, " RISE_FLAG"}, 16'(RISE_FLAG), 16'h0);
        check({tag, " FALL_FLAG"}, 16'(FALL_FLAG), 16'h0);
    endtask

    // One clock: model consumes the inputs seen at the edge, DUT sampled 1 after.
    task automatic step(input string tag);
        model_step(PAD_IN, DB_EN, EDGE_CLR, int'(PRESCALE));
        @(posedge HCLK);
        #1;
        compare_all(tag);
    endtask

    // Asserted between edges so the clear has to be asynchronous.
    task automatic do_reset(input string tag);
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_zero({tag, " async"});
        @(posedge HCLK);
        #1;
        check_zero({tag, " held"});
        #2;
        HRESETn = 1'b1;
    endtask

    // Steps until DIN_CLEAN[bit] == val; n = steps taken, bound+1 on timeout.
    task automatic wait_din(input string tag, input int b, input logic val, input int bound,
                            output int n, output int rises);
        n = 0;
        rises = 0;
        while (n <= bound) begin
            step(tag);
            n++;
            if (RISE[b]) rises++;
            if (DIN_CLEAN[b] == val) break;
        end
        if (DIN_CLEAN[b] != val) n = bound + 1;
    endtask

    typedef struct {
        logic [SZ-1:0] pad;
        logic [SZ-1:0] din;
        logic [SZ-1:0] rise;
        logic [SZ-1:0] fall;
        logic [SZ-1:0] rf;
        logic [SZ-1:0] ff;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rises, pre_steps, n_0f, n_ff;

        //            pad    din    rise   fall   rf     ff
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
        tbl[4]  = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00};
        tbl[5]  = '{8'h0F, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00};
        tbl[6]  = '{8'h0F, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00};
        tbl[7]  = '{8'h0F, 8'h0F, 8'h0A, 8'hA0, 8'hA5, 8'h00};
        tbl[8]  = '{8'h0F, 8'h0F, 8'h00, 8'h00, 8'hAF, 8'hA0};
        tbl[9]  = '{8'h00, 8'h0F, 8'h00, 8'h00, 8'hAF, 8'hA0};
        tbl[10] = '{8'h00, 8'h0F, 8'h00, 8'h00, 8'hAF, 8'hA0};
        tbl[11] = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'hAF, 8'hA0};
        tbl[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAF, 8'hAF};

        // Bypass path from the vector table
        do_reset("reset0");
        DB_EN = '0;
        PRESCALE = '0;
        for (int i = 0; i < 13; i++) begin
            PAD_IN = tbl[i].pad;
            model_step(PAD_IN, DB_EN, EDGE_CLR, int'(PRESCALE));
            @(posedge HCLK);
            #1;
            check($sformatf("vec%0d DIN_CLEAN", i), 16'(DIN_CLEAN), 16'(tbl[i].din));
            check($sformatf("vec%0d RISE", i),      16'(RISE),      16'(tbl[i].rise));
            check($sformatf("vec%0d FALL", i),      16'(FALL),      16'(tbl[i].fall));
            check($sformatf("vec%0d RISE_FLAG", i), 16'(RISE_FLAG), 16'(tbl[i].rf));
            check($sformatf("vec%0d FALL_FLAG", i), 16'(FALL_FLAG), 16'(tbl[i].ff));
        end

        // Mid-sequence reset clears everything; release gives no pulses
        PAD_IN = 8'h00;
        do_reset("reset_mid");
        for (int i = 0; i < 4; i++) step("post_reset");

        // Debounce accept on pin 0 with a random prescaler phase
        do_reset("reset_db");
        DB_EN = 8'h01;
        PRESCALE = 16'd3;
        pre_steps = $urandom_range(0, 3);
        for (int i = 0; i < pre_steps; i++) step("db_phase");
        PAD_IN = 8'h01;
        wait_din("db_accept", 0, 1'b1, 40, n, rises);
        checks++;
        if (n < 15 || n > 18) begin
            errors++;
            $display("FAIL db_accept_latency: got %0d expected 15..18", n);
        end
        for (int i = 0; i < 6; i++) begin
            step("db_after");
            if (RISE[0]) rises++;
        end
        check("db_single_rise", 16'(rises), 16'd1);
        check("db_rise_flag", 16'(RISE_FLAG), 16'h01);

        // Glitch reject: 10 cycles high is fewer than DB_CNT ticks
        do_reset("reset_gl");
        DB_EN = 8'h01;
        PRESCALE = 16'd3;
        PAD_IN = 8'h01;
        for (int i = 0; i < 10; i++) step("glitch_hi");
        PAD_IN = 8'h00;
        for (int i = 0; i < 25; i++) step("glitch_lo");
        check("glitch_din", 16'(DIN_CLEAN), 16'h0);
        check("glitch_flag", 16'(RISE_FLAG), 16'h0);

        // A one-cycle dip restarts acceptance from scratch
        PAD_IN = 8'h01;
        for (int i = 0; i < 8; i++) step("dip_hi");
        PAD_IN = 8'h00;
        step("dip_lo");
        PAD_IN = 8'h01;
        wait_din("dip_accept", 0, 1'b1, 40, n, rises);
        checks++;
        if (n < 15 || n > 18) begin
            errors++;
            $display("FAIL dip_restart_latency: got %0d expected 15..18", n);
        end

        // Set beats a simultaneous clear, then clear takes effect
        do_reset("reset_flag");
        DB_EN = '0;
        PAD_IN = 8'h08;
        for (int i = 0; i < 5; i++) step("flag_hi");
        PAD_IN = 8'h00;
        n = 0;
        while (!FALL[3] && n < 10) begin
            step("flag_wait");
            n++;
        end
        check("flag_fall_seen", 16'(FALL[3]), 16'h1);
        EDGE_CLR = 8'h08;
        step("flag_setclr");
        check("flag_set_wins", 16'(FALL_FLAG[3]), 16'h1);
        step("flag_clr");
        check("flag_cleared", 16'(FALL_FLAG[3]), 16'h0);
        EDGE_CLR = '0;
        step("flag_idle");

        // Prescale lowered from 0xFFFF at count 0x8000 must wrap immediately
        do_reset("reset_ps");
        DB_EN = 8'h01;
        PRESCALE = 16'hFFFF;
        PAD_IN = 8'h00;
        for (int i = 0; i < 32768; i++) step("ps_long");
        PRESCALE = 16'd2;
        PAD_IN = 8'h01;
        wait_din("ps_accept", 0, 1'b1, 25, n, rises);
        check("ps_wrap_latency", 16'(n), 16'd13);

        // Mixed pins: low nibble bypassed, high nibble debounced
        do_reset("reset_mix");
        DB_EN = 8'hF0;
        PRESCALE = 16'd1;
        PAD_IN = 8'hFF;
        n_0f = 0;
        n_ff = 0;
        for (int i = 1; i <= 30; i++) begin
            step("mixed");
            if (DIN_CLEAN == 8'h0F && n_0f == 0) n_0f = i;
            if (DIN_CLEAN == 8'hFF && n_ff == 0) n_ff = i;
        end
        check("mixed_low_nibble", 16'(n_0f), 16'd3);
        check("mixed_full", 16'(n_ff), 16'd10);

        // Randomized run against the model
        do_reset("reset_rand");
        PAD_IN = '0;
        DB_EN = 8'($urandom);
        PRESCALE = 16'($urandom_range(0, 3));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) DB_EN = 8'($urandom);
            if ($urandom_range(0, 99) == 0) PRESCALE = 16'($urandom_range(0, 3));
            PAD_IN   = PAD_IN ^ 8'($urandom & $urandom & $urandom);
            EDGE_CLR = 8'($urandom & $urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
